// File: rtl/mux2_burst_arbiter_pkg.sv
// Shared state encodings, default burst cap and the round-robin arbitration function
// for the two-requester burst arbiter.
package mux2_burst_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam int unsigned DEFAULT_MAX_BURST = 8;

    // prio picks the winner only when both requesters compete.
    function automatic logic [1:0] arbitrate(input logic r0, input logic r1, input logic prio);
        logic [1:0] st;
        if (r0 && r1) begin
            st = prio ? ST_GNT1 : ST_GNT0;
        end else if (r0) begin
            st = ST_GNT0;
        end else if (r1) begin
            st = ST_GNT1;
        end else begin
            st = ST_IDLE;
        end
        return st;
    endfunction

endpackage

// File: rtl/mux2_datapath.sv
// W-wide 2:1 mux whose output is forced to zero whenever no valid beat is presented.
module mux2_datapath #(
    parameter int unsigned W = 1
) (
    input  logic         sel,
    input  logic         valid,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] q
);

    always_comb begin
        q = '0;
        if (valid) begin
            q = sel ? d1 : d0;
        end
    end

endmodule

// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter owning the select of a shared 2:1 datapath mux; a grant is held
// until the owner ends its burst with last, reaches MAX_BURST beats, or drops its request.
module mux2_burst_arbiter
    import mux2_burst_arbiter_pkg::*;
#(
    parameter int unsigned W         = 1,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] d0,
    input  logic         last0,
    input  logic         req1,
    input  logic [W-1:0] d1,
    input  logic         last1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         sel,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         burst_done
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d, cnt_inc;
    logic            prio_q, prio_d;
    logic            gnt0_q, gnt1_q, sel_q, burst_done_q;

    logic owner_req, owner_last, granted, xfer, release_grant;

    always_comb begin
        owner_req     = ((state_q == ST_GNT0) && req0) || ((state_q == ST_GNT1) && req1);
        owner_last    = (state_q == ST_GNT1) ? last1 : last0;
        granted       = (state_q != ST_IDLE);
        xfer          = owner_req && out_ready;
        cnt_inc       = beat_cnt_q + 1'b1;
        // An owner that stops requesting forfeits the grant without a counted beat.
        release_grant = (granted && !owner_req) ||
                        (xfer && (owner_last || (cnt_inc == CntW'(MAX_BURST))));
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        prio_d     = prio_q;
        if (state_q == ST_IDLE) begin
            state_d = arbitrate(req0, req1, prio_q);
        end else if (release_grant) begin
            // Hand priority to the other side first so a waiting peer wins this same cycle.
            prio_d     = (state_q == ST_GNT0);
            state_d    = arbitrate(req0, req1, prio_d);
            beat_cnt_d = '0;
        end else if (xfer) begin
            beat_cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            prio_q       <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            sel_q        <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            prio_q       <= prio_d;
            gnt0_q       <= (state_d == ST_GNT0);
            gnt1_q       <= (state_d == ST_GNT1);
            sel_q        <= (state_d == ST_GNT1);
            burst_done_q <= granted && release_grant;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign sel        = sel_q;
    assign burst_done = burst_done_q;
    assign out_valid  = owner_req;

    mux2_datapath #(
        .W(W)
    ) u_datapath (
        .sel  (sel_q),
        .valid(owner_req),
        .d0   (d0),
        .d1   (d1),
        .q    (out_data)
    );

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Scoreboard bench: directed stimulus queues expected beats, a negedge monitor pops and compares
// every accepted beat, and grant/burst_done behaviour is checked directly at each step.
module tb_mux2_burst_arbiter;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic         sel;
        logic [W-1:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, last0, req1, last1, out_ready;
    logic [W-1:0] d0, d1;
    logic         gnt0, gnt1, sel, out_valid, burst_done;
    logic [W-1:0] out_data;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    mux2_burst_arbiter #(
        .W        (W),
        .MAX_BURST(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .d0        (d0),
        .last0     (last0),
        .req1      (req1),
        .d1        (d1),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [W-1:0] d);
        beat_t b;
        b.sel  = s;
        b.data = d;
        exp_q.push_back(b);
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        d0 = '0; d1 = 8'hA5; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got sel=%0d data=%0h, expected no beat (t=%0t)",
                         sel, out_data, $time);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_sel", {31'd0, sel}, {31'd0, e.sel});
                chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_gnt0", {31'd0, gnt0}, 0);
        chk("rst_gnt1", {31'd0, gnt1}, 0);
        chk("rst_sel", {31'd0, sel}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_done", {31'd0, burst_done}, 0);

        // Single requester, three-beat burst ended by last0.
        req0 = 1'b1; d0 = 8'h01;
        tick();
        chk("s1_gnt0", {31'd0, gnt0}, 1);
        chk("s1_sel", {31'd0, sel}, 0);
        for (int i = 0; i < 3; i++) begin
            last0 = (i == 2);
            push(1'b0, 8'h01);
            tick();
        end
        chk("s1_done", {31'd0, burst_done}, 1);
        chk("s1_regrant", {31'd0, gnt0}, 1);
        req0 = 1'b0; last0 = 1'b0;
        #1;
        chk("s1_abandon_valid", {31'd0, out_valid}, 0);
        tick();
        chk("s1_idle_gnt0", {31'd0, gnt0}, 0);
        tick();
        chk("s1_done_clear", {31'd0, burst_done}, 0);

        // Continuous contention, last on every second beat: G0,G0,G1,G1,G0,G0.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            logic       se;
            logic [7:0] a, b;
            se = ((i / 2) % 2) == 1;
            a  = 8'h10 + 8'(i);
            b  = 8'h20 + 8'(i);
            d0 = a; d1 = b;
            last0 = (i % 2) == 1; last1 = (i % 2) == 1;
            push(se, se ? b : a);
            #1;
            chk("s2_gnt0", {31'd0, gnt0}, {31'd0, !se});
            chk("s2_gnt1", {31'd0, gnt1}, {31'd0, se});
            chk("s2_done", {31'd0, burst_done}, {31'd0, (i == 2) || (i == 4)});
            tick();
        end
        chk("s2_final_gnt1", {31'd0, gnt1}, 1);
        chk("s2_final_done", {31'd0, burst_done}, 1);
        idle_inputs();

        // Requester 1 alone, never last: forced release every 8 beats.
        do_reset();
        req1 = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            d1 = 8'h30 + 8'(i);
            push(1'b1, 8'h30 + 8'(i));
            #1;
            chk("s3_gnt1", {31'd0, gnt1}, 1);
            chk("s3_done", {31'd0, burst_done}, {31'd0, i == 8});
            tick();
        end
        chk("s3_done_16", {31'd0, burst_done}, 1);
        chk("s3_gnt1_16", {31'd0, gnt1}, 1);
        idle_inputs();

        // Backpressure with last0 held: grant sticks until a real transfer.
        do_reset();
        req0 = 1'b1; last0 = 1'b1; d0 = 8'h44; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s4_hold_gnt0", {31'd0, gnt0}, 1);
            chk("s4_hold_done", {31'd0, burst_done}, 0);
            chk("s4_hold_valid", {31'd0, out_valid}, 1);
            chk("s4_hold_data", {24'd0, out_data}, 32'h44);
            tick();
        end
        out_ready = 1'b1; req1 = 1'b1; d1 = 8'h55;
        push(1'b0, 8'h44);
        tick();
        chk("s4_rel_gnt1", {31'd0, gnt1}, 1);
        chk("s4_rel_gnt0", {31'd0, gnt0}, 0);
        chk("s4_rel_done", {31'd0, burst_done}, 1);
        idle_inputs();

        // Requester 1 abandons after 3 beats while requester 0 waits.
        do_reset();
        req1 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            d1 = 8'h60 + 8'(i);
            push(1'b1, 8'h60 + 8'(i));
            tick();
        end
        req1 = 1'b0; req0 = 1'b1; d0 = 8'h66;
        #1;
        chk("s5_abandon_valid", {31'd0, out_valid}, 0);
        tick();
        chk("s5_gnt0", {31'd0, gnt0}, 1);
        chk("s5_gnt1", {31'd0, gnt1}, 0);
        chk("s5_done", {31'd0, burst_done}, 1);
        chk("s5_sel", {31'd0, sel}, 0);
        last0 = 1'b1; req1 = 1'b1; d0 = 8'h67;
        push(1'b0, 8'h67);
        tick();
        chk("s5_rr_gnt1", {31'd0, gnt1}, 1);
        idle_inputs();
        tick();
        tick();

        // Async reset mid-burst while prio favours requester 1; tie must revert to requester 0.
        req0 = 1'b1; last0 = 1'b1; d0 = 8'h77;
        tick();
        push(1'b0, 8'h77);
        tick();
        req1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_gnt0", {31'd0, gnt0}, 0);
        chk("s6_gnt1", {31'd0, gnt1}, 0);
        chk("s6_sel", {31'd0, sel}, 0);
        chk("s6_valid", {31'd0, out_valid}, 0);
        chk("s6_data", {24'd0, out_data}, 0);
        chk("s6_done", {31'd0, burst_done}, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("s6_tie_gnt0", {31'd0, gnt0}, 1);
        chk("s6_tie_gnt1", {31'd0, gnt1}, 0);
        chk("s6_no_done", {31'd0, burst_done}, 0);
        idle_inputs();
        tick();
        tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
